// File: rtl/add_tree_operand_loader.sv
// add_tree_operand_loader
// Packs a byte-serial valid/ready stream into one 8-operand frame (n1..n8)
// for the parallel adder tree. A short frame, ended with in_last, is padded
// with zeros so that the tree sum is unchanged. The finished frame is held
// until the consumer takes it.
// Optional build macro LOADER_SUM_CHECK_EN adds the exp_sum output. exp_sum is
// the modulo-2^W sum of the bytes in the frame, so the tree result can be
// checked inline.
module add_tree_operand_loader #(
    parameter int W     = 8,
    parameter int SLOTS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         abort,
    output logic [W-1:0] n1,
    output logic [W-1:0] n2,
    output logic [W-1:0] n3,
    output logic [W-1:0] n4,
    output logic [W-1:0] n5,
    output logic [W-1:0] n6,
    output logic [W-1:0] n7,
    output logic [W-1:0] n8,
    output logic [3:0]   out_count,
    output logic         out_valid,
    input  logic         out_ready
`ifdef LOADER_SUM_CHECK_EN
    ,
    output logic [W-1:0] exp_sum
`endif
);

    localparam int CW = $clog2(SLOTS);
    localparam logic [CW-1:0] LAST_IDX = CW'(SLOTS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic [3:0]    out_count_reg, out_count_next;

    logic               accept;
    logic               frame_done;
    logic               handoff;
    logic [SLOTS*W-1:0] slot_flat;

    // Bytes are accepted only while filling. Reset also blocks acceptance.
    assign in_ready   = (state_reg == FILL) && !rst;
    assign accept     = in_valid && in_ready;
    // The frame closes on the 8th byte, or on any byte that carries in_last.
    assign frame_done = accept && (in_last || (cnt_reg == LAST_IDX));
    assign handoff    = out_valid_reg && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FILL;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            out_count_reg <= out_count_next;
        end
    end

    // Next-state logic. abort takes priority over an accept or a handoff in the same cycle.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        out_count_next = out_count_reg;
        if (abort) begin
            state_next     = FILL;
            cnt_next       = '0;
            out_valid_next = 1'b0;
            out_count_next = '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        cnt_next = cnt_reg + 1'b1;
                        if (frame_done) begin
                            state_next     = FULL;
                            out_valid_next = 1'b1;
                            out_count_next = {1'b0, cnt_reg} + 4'd1;
                        end
                    end
                end
                FULL: begin
                    if (handoff) begin
                        state_next     = FILL;
                        out_valid_next = 1'b0;
                        cnt_next       = '0;
                        out_count_next = '0;
                    end
                end
                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

    // One register per operand slot. Each slot loads when the write pointer
    // selects it. It is cleared on abort and on handoff.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [W-1:0] slot_reg, slot_next;

            // Slot update. The slots above the last byte of a short frame are
            // forced to zero when the frame closes.
            always_comb begin
                slot_next = slot_reg;
                if (abort) begin
                    slot_next = '0;
                end else if (accept) begin
                    if (cnt_reg == CW'(gi)) begin
                        slot_next = in_data;
                    end else if (frame_done && (CW'(gi) > cnt_reg)) begin
                        slot_next = '0;
                    end
                end else if (handoff) begin
                    slot_next = '0;
                end
            end

            // Slot register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign slot_flat[gi*W +: W] = slot_reg;
        end
    endgenerate

    assign n1        = slot_flat[0*W +: W];
    assign n2        = slot_flat[1*W +: W];
    assign n3        = slot_flat[2*W +: W];
    assign n4        = slot_flat[3*W +: W];
    assign n5        = slot_flat[4*W +: W];
    assign n6        = slot_flat[5*W +: W];
    assign n7        = slot_flat[6*W +: W];
    assign n8        = slot_flat[7*W +: W];
    assign out_count = out_count_reg;
    assign out_valid = out_valid_reg;

`ifdef LOADER_SUM_CHECK_EN
    logic [W-1:0] sum_reg, sum_next;

    // Running sum of the accepted bytes, wrapping at 2^W.
    always_comb begin
        sum_next = sum_reg;
        if (abort) begin
            sum_next = '0;
        end else if (accept) begin
            sum_next = sum_reg + in_data;
        end else if (handoff) begin
            sum_next = '0;
        end
    end

    // Sum register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign exp_sum = sum_reg;
`endif

endmodule

// File: tb/tb_add_tree_operand_loader.sv
// Testbench for add_tree_operand_loader.
// The bench runs a table of directed frames, hand-written sequences for
// abort and reset, and randomized frames. The randomized frames are checked
// against a model that pads the frame with zeros and sums the bytes.
module tb_add_tree_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_count;
    logic [7:0] n1, n2, n3, n4, n5, n6, n7, n8;
`ifdef LOADER_SUM_CHECK_EN
    logic [7:0] exp_sum;
`endif

    add_tree_operand_loader #(.W(8), .SLOTS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .abort     (abort),
        .n1        (n1),
        .n2        (n2),
        .n3        (n3),
        .n4        (n4),
        .n5        (n5),
        .n6        (n6),
        .n7        (n7),
        .n8        (n8),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LOADER_SUM_CHECK_EN
        ,
        .exp_sum   (exp_sum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] n_arr [8];
    always_comb begin
        n_arr[0] = n1; n_arr[1] = n2; n_arr[2] = n3; n_arr[3] = n4;
        n_arr[4] = n5; n_arr[5] = n6; n_arr[6] = n7; n_arr[7] = n8;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] b [8];
        int         len;
        bit         last_on_final;
        logic [7:0] exp_n [8];
        int         exp_cnt;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Offers one byte after gap idle cycles. The idle cycles carry random data
    // and a random in_last. The task returns one time unit after the edge that accepted the byte.
    task automatic send(input logic [7:0] b, input bit last, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 40) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e [8], input int cnt,
                             input logic [7:0] s);
        chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'd1);
        chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s n%0d", tag, i + 1), 32'(n_arr[i]), 32'(e[i]));
        chk($sformatf("%s out_count", tag), 32'(out_count), 32'(cnt));
`ifdef LOADER_SUM_CHECK_EN
        chk($sformatf("%s exp_sum", tag), 32'(exp_sum), 32'(s));
`else
        if (s === 8'hxx) $display("unused");
`endif
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s out_valid", tag), 32'(out_valid), 32'd0);
        chk($sformatf("%s out_count", tag), 32'(out_count), 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s n%0d", tag, i + 1), 32'(n_arr[i]), 32'd0);
`ifdef LOADER_SUM_CHECK_EN
        chk($sformatf("%s exp_sum", tag), 32'(exp_sum), 32'd0);
`endif
    endtask

    task automatic do_handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_idle(tag);
        chk($sformatf("%s in_ready", tag), 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e [8];
        logic [7:0] rb [8];
        logic [7:0] re [8];
        logic [7:0] rs;
        int         rlen;
        bit         rlast;

        // Directed frames, each with its expected result.
        vecs[0].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].len = 8; vecs[0].last_on_final = 1'b0;
        vecs[0].exp_n = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].exp_cnt = 8; vecs[0].exp_s = 8'h24;

        vecs[1].b = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].len = 3; vecs[1].last_on_final = 1'b1;
        vecs[1].exp_n = '{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].exp_cnt = 3; vecs[1].exp_s = 8'h60;

        vecs[2].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].len = 8; vecs[2].last_on_final = 1'b0;
        vecs[2].exp_n = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2].exp_cnt = 8; vecs[2].exp_s = 8'hF8;

        vecs[3].b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        vecs[3].len = 8; vecs[3].last_on_final = 1'b1;
        vecs[3].exp_n = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        vecs[3].exp_cnt = 8; vecs[3].exp_s = 8'h64;

        vecs[4].b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].len = 1; vecs[4].last_on_final = 1'b1;
        vecs[4].exp_n = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4].exp_cnt = 1; vecs[4].exp_s = 8'h5A;

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk_idle("rst");
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", 32'(in_ready), 32'd1);

        // Directed frames. in_valid alternates during the fill and stays high
        // with junk data while the frame is held.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].len; i++) begin
                send(vecs[v].b[i], vecs[v].last_on_final && (i == vecs[v].len - 1), i % 2);
                if (i < vecs[v].len - 1)
                    chk($sformatf("vec%0d early out_valid", v), 32'(out_valid), 32'd0);
            end
            chk_frame($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_cnt, vecs[v].exp_s);
            in_valid = 1'b1;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            for (int h = 0; h < 5; h++) begin
                @(posedge clk); #1;
                chk_frame($sformatf("vec%0d hold%0d", v, h), vecs[v].exp_n, vecs[v].exp_cnt,
                          vecs[v].exp_s);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            do_handoff($sformatf("vec%0d handoff", v));
        end

        // Abort after five bytes, asserted together with a valid byte 0x77.
        for (int i = 0; i < 5; i++) send(8'(i + 1), 1'b0, 0);
        in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk_idle("abort_fill");
        chk("abort_fill in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i), 1'b0, 0);
        e = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        chk_frame("after_abort", e, 8, 8'h1C);
        do_handoff("after_abort handoff");

        // Abort together with out_ready while a frame is held.
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b0, 0);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        chk_idle("abort_full");
        chk("abort_full in_ready", 32'(in_ready), 32'd1);
        send(8'h44, 1'b0, 0);
        send(8'h55, 1'b1, 0);
        e = '{8'h44, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("after_abort_full", e, 2, 8'h99);
        do_handoff("after_abort_full handoff");

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i), 1'b0, 0);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk_idle("midrst");
        rst = 1'b0;
        #1;
        chk("midrst release in_ready", 32'(in_ready), 32'd1);
        send(8'hC1, 1'b0, 0);
        send(8'hC2, 1'b0, 0);
        send(8'hC3, 1'b1, 0);
        e = '{8'hC1, 8'hC2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_frame("after_rst", e, 3, 8'h46);
        do_handoff("after_rst handoff");

        // Randomized frames checked against the padded-frame model.
        for (int f = 0; f < 40; f++) begin
            rlen  = $urandom_range(1, 8);
            rlast = (rlen < 8) ? 1'b1 : 1'($urandom);
            rs    = 8'h00;
            for (int i = 0; i < 8; i++) begin
                rb[i] = 8'($urandom);
                re[i] = (i < rlen) ? rb[i] : 8'h00;
                if (i < rlen) rs = rs + rb[i];
            end
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = $urandom_range(0, rlen - 1);
                for (int i = 0; i < k; i++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
                in_valid = 1'b1; in_data = 8'($urandom); abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0; in_valid = 1'b0;
                chk_idle($sformatf("rnd%0d abort", f));
            end
            for (int i = 0; i < rlen; i++)
                send(rb[i], rlast && (i == rlen - 1), $urandom_range(0, 2));
            chk_frame($sformatf("rnd%0d", f), re, rlen, rs);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            for (int h = $urandom_range(0, 4); h > 0; h--) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            chk_frame($sformatf("rnd%0d held", f), re, rlen, rs);
            do_handoff($sformatf("rnd%0d handoff", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_tree_operand_loader.md
Name: add_tree_operand_loader

Overview:
- Producer-side front end for the 8-input, 8-bit adder tree.
- Accepts a serial byte stream over a valid/ready handshake and packs up to 8 bytes into parallel operand slots n1..n8.
- Presents a complete operand frame with out_valid, holds it until the consumer takes it, then starts the next frame.
- Lets a byte-serial source drive the parallel tree without external glue.

Parameters:
- W, 8, operand width in bits; matches tree operand width.
- SLOTS, 8, operands per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  W  serial operand byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks final byte of a short frame; qualified by in_valid.
- in_ready  output  1  loader can accept a byte this cycle.
- abort  input  1  synchronous frame discard.
- n1..n8  output  W each  parallel operands to tree; n1 = first byte received.
- out_count  output  4  number of real operands in frame, 1..8.
- out_valid  output  1  frame on n1..n8 is complete and stable.
- out_ready  input  1  consumer takes frame.

Behaviour:
- States: FILL, FULL. Reset values:
  - state = FILL, cnt = 0
  - all slots 0, out_valid 0, out_count 0
- in_ready = (state == FILL) && !rst. Combinational; no bytes are accepted in FULL.
- Accept = in_valid && in_ready.
  - On accept: slot[cnt] <= in_data, cnt <= cnt+1.
- FILL -> FULL on either:
  - accept with cnt == 7, or
  - accept with in_last == 1 (any cnt).
- On that transition:
  - out_count <= cnt+1.
  - Slots with index > cnt are written 0 in the same cycle (zero padding, sum-neutral).
  - out_valid rises the next cycle.
- Latency: last byte accepted at edge k -> out_valid = 1 and n1..n8 stable after edge k.
- FULL: n1..n8, out_count held constant while out_valid = 1 and !out_ready.
- FULL -> FILL when out_valid && out_ready. Same edge:
  - out_valid <= 0, cnt <= 0, all slots <= 0, out_count <= 0.
  - in_ready goes 1 the following cycle. There is no same-cycle handoff/refill overlap; minimum frame period is 9 cycles.
- in_last with cnt == 7 behaves identically to a normal 8th byte.
- in_last is ignored when in_valid == 0 or in_ready == 0.
- abort (any state):
  - Next edge: cnt = 0, slots = 0, out_valid = 0, out_count = 0, state = FILL.
  - abort wins over a simultaneous accept or out_ready; the byte is dropped.
- rst mid-frame: identical result to abort. rst has priority over everything.
- in_data/in_valid are don't-care in FULL. The loader never stalls a frame half-filled: it waits indefinitely for bytes.
- Width rule: data is passed unmodified; no arithmetic in the base block.

Optional Feature:
- Macro LOADER_SUM_CHECK_EN.
- When defined, adds output exp_sum [W-1:0]:
  - Running sum of accepted bytes, modulo 2^W.
  - Updated on each accept; cleared on handoff, abort and rst.
  - Valid whenever out_valid = 1.
  - Equals the tree output S for the presented frame, for inline self-check.
- When undefined: port and adder absent; behaviour otherwise identical.

Test Plan:
- Full frame: reset, stream 0x01..0x08, out_ready = 0.
  - Expected: in_ready drops after 8th accept; out_valid = 1; n1 = 0x01 .. n8 = 0x08; out_count = 8; exp_sum = 0x24. Hold 5 cycles, verify stable; pulse out_ready, verify out_valid = 0 next cycle and all n = 0.
- Short frame: bytes 0x10, 0x20, 0x30 with in_last on 0x30.
  - Expected: out_count = 3; n1..n3 = 0x10, 0x20, 0x30; n4..n8 = 0; exp_sum = 0x60.
- Overflow: eight bytes of 0xFF.
  - Expected: exp_sum = 0xF8; all slots 0xFF; out_count = 8.
- Backpressure/stall: in_valid toggled 1010... during fill, in_valid held 1 during FULL.
  - Expected: exactly 8 bytes captured in order; no byte accepted while out_valid = 1.
- Abort: after 5 bytes, assert abort together with in_valid (byte 0x77).
  - Expected: 0x77 dropped; cnt = 0; a new 8-byte frame 0xA0..0xA7 presents n1 = 0xA0.
  - Repeat with abort asserted simultaneously with out_ready in FULL: frame dropped, out_valid = 0.
- Reset mid-frame: rst for 1 cycle after 4 bytes.
  - Expected: all outputs at reset values; in_ready = 0 during rst, 1 after. The next frame loads from n1.
